// File: rtl/mul_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_add_seq
// Description : Sequential shift-and-add multiply-accumulate, p = q*b + r.
//               One multiplier bit is consumed per clock. It can rebuild a
//               divider's dividend from quotient, divisor and remainder.
//               Uses a start/busy/done handshake. p holds its value until the
//               next operation completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               fits
);

  // The iteration counter only has to reach WIDTH-1, so it never wraps.
  localparam int             c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_CW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_accept;
  logic               w_last;

  // Accumulator after this iteration. The worst case is 2^(2W) - 2^W, so
  // 2*WIDTH bits are enough and no carry-out is kept.
  assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);

  // State register; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. start is ignored outside IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (r_cnt == c_LAST) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then shift and add once per clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_acc    <= {{WIDTH{1'b0}}, r};
      r_mcand  <= {{WIDTH{1'b0}}, b};
      r_mplier <= q;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + c_CW'(1);
    end
  end

  // Result register: written only on the final iteration, else held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p <= '0;
    end else if (w_last) begin
      r_p <= w_sum;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign p    = r_p;
  assign fits = ~|r_p[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_mul_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_add_seq
// Description : Self-checking bench for mul_add_seq against an arithmetic
//               reference (q*b + r) with directed and random operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_add_seq;

  localparam int W = 32;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [W-1:0]     q, b, r;
  logic             busy, done, fits;
  logic [2*W-1:0]   p;

  int errors = 0;
  int checks = 0;

  mul_add_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .q       (q),
    .b       (b),
    .r       (r),
    .busy    (busy),
    .done    (done),
    .p       (p),
    .fits    (fits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: the product and sum in plain 2W-bit arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] mq,
                                           input logic [W-1:0] mb,
                                           input logic [W-1:0] mr);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, mq} * {{W{1'b0}}, mb};
    return prod + {{W{1'b0}}, mr};
  endfunction

  function automatic logic model_fits(input logic [2*W-1:0] v);
    return (v < (65'd1 << W));
  endfunction

  // Drives one operation and reports what was observed (no checking here).
  // done_lat: cycles after the accepting edge until done (-1 = never).
  task automatic launch(input  logic [W-1:0]   lq, lb, lr,
                        output int             busy_bad,
                        output int             done_lat,
                        output logic           done_next,
                        output logic [2*W-1:0] pv,
                        output logic           fv);
    busy_bad  = 0;
    done_lat  = -1;
    done_next = 1'b1;
    pv        = '0;
    fv        = 1'b0;
    @(negedge clock);
    q = lq; b = lb; r = lr; start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 3 * W; n++) begin
      @(negedge clock);
      if (n == 1) start = 1'b0;
      if (done) begin
        done_lat = n;
        pv = p;
        fv = fits;
        break;
      end
      if (!busy) busy_bad++;
    end
    @(negedge clock);
    done_next = done;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; q = '0; b = '0; r = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (p !== '0 || fits !== 1'b1) begin
      errors++;
      $display("FAIL reset_p: p=%h fits=%b required 0 1", p, fits);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_no_start;
    int seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0 || p !== '0 || fits !== 1'b1) begin
      errors++;
      $display("FAIL idle_no_start: activity=%0d p=%h fits=%b required 0 0 1", seen, p, fits);
    end
  endtask

  task automatic test_basic;
    int bb, lat; logic dn, fv; logic [2*W-1:0] pv;
    launch(32'd7, 32'd9, 32'd3, bb, lat, dn, pv, fv);
    checks++;
    if (bb != 0) begin
      errors++;
      $display("FAIL basic_busy: busy low in %0d run cycles required 0", bb);
    end
    checks++;
    if (lat != W + 1 || dn !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: latency=%0d next=%b required %0d 0", lat, dn, W + 1);
    end
    checks++;
    if (pv !== 64'd66 || fv !== 1'b1) begin
      errors++;
      $display("FAIL basic_p: p=%h fits=%b required 42 1", pv, fv);
    end
  endtask

  task automatic test_boundary;
    int bb, lat; logic dn, fv; logic [2*W-1:0] pv;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bb, lat, dn, pv, fv);
    checks++;
    if (pv !== 64'hFFFF_FFFF_0000_0000 || fv !== 1'b0 || lat != W + 1) begin
      errors++;
      $display("FAIL max_operands: p=%h fits=%b lat=%0d required ffffffff00000000 0 %0d", pv, fv, lat, W + 1);
    end
    launch(32'h1_0000, 32'h1_0000, 32'd0, bb, lat, dn, pv, fv);
    checks++;
    if (pv !== 64'h1_0000_0000 || fv !== 1'b0) begin
      errors++;
      $display("FAIL pow2_square: p=%h fits=%b required 100000000 0", pv, fv);
    end
  endtask

  task automatic test_round_trip;
    int bb, lat; logic dn, fv; logic [2*W-1:0] pv;
    launch(32'd142, 32'd7, 32'd6, bb, lat, dn, pv, fv);
    checks++;
    if (pv !== 64'd1000 || fv !== 1'b1) begin
      errors++;
      $display("FAIL round_trip: p=%0d fits=%b required 1000 1", pv, fv);
    end
    launch(32'd5, 32'd0, 32'h1234, bb, lat, dn, pv, fv);
    checks++;
    if (pv !== 64'h1234 || fv !== 1'b1) begin
      errors++;
      $display("FAIL zero_divisor: p=%h fits=%b required 1234 1", pv, fv);
    end
  endtask

  task automatic test_random;
    int bb, lat; logic dn, fv; logic [2*W-1:0] pv, exp_p;
    logic [W-1:0] rq, rb, rr;
    for (int i = 0; i < 10; i++) begin
      rq = $urandom; rb = $urandom; rr = $urandom;
      if (i % 3 == 1) rq = rq >> 16;
      if (i % 3 == 2) begin rb = rb >> 20; rq = rq >> 20; end
      exp_p = model(rq, rb, rr);
      launch(rq, rb, rr, bb, lat, dn, pv, fv);
      checks++;
      if (pv !== exp_p || fv !== model_fits(exp_p) || lat != W + 1 || bb != 0) begin
        errors++;
        $display("FAIL random_%0d: q=%h b=%h r=%h p=%h fits=%b lat=%0d required p=%h fits=%b lat=%0d",
                 i, rq, rb, rr, pv, fv, lat, exp_p, model_fits(exp_p), W + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    int done_at[$];
    int low_runs[$];
    int low_len, p_bad;
    logic seen_high, prev_busy;
    done_at.delete(); low_runs.delete();
    low_len = 0; p_bad = 0; seen_high = 1'b0; prev_busy = 1'b0;
    @(negedge clock);
    q = 32'd3; b = 32'd5; r = 32'd1; start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (done) begin
        done_at.push_back(n);
        if (p !== 64'd16) p_bad++;
      end
      if (busy) begin
        if (seen_high && !prev_busy) low_runs.push_back(low_len);
        seen_high = 1'b1;
        low_len = 0;
      end else begin
        low_len++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    checks++;
    if (done_at.size() != 2 || done_at[0] != W + 1 || done_at[1] - done_at[0] != W + 2) begin
      errors++;
      $display("FAIL b2b_spacing: count=%0d first=%0d gap=%0d required 2 %0d %0d",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1,
               (done_at.size() > 1) ? done_at[1] - done_at[0] : -1, W + 1, W + 2);
    end
    checks++;
    if (p_bad != 0) begin
      errors++;
      $display("FAIL b2b_p: %0d done pulses with p!=16 (last p=%0d) required 0", p_bad, p);
    end
    checks++;
    if (low_runs.size() < 2 || low_runs[0] != 2 || low_runs[1] != 2) begin
      errors++;
      $display("FAIL b2b_gap: gaps=%0d first=%0d required >=2 gaps of 2",
               low_runs.size(), (low_runs.size() > 0) ? low_runs[0] : -1);
    end
    // Let the run that was in flight finish.
    for (int n = 0; n < 3 * W; n++) begin
      @(negedge clock);
      if (!busy && !done) break;
    end
    checks++;
    if (busy || done) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_ignore_changes;
    logic [2*W-1:0] exp_p;
    int lat;
    exp_p = model(32'hABCD, 32'h1234, 32'd0);
    lat = -1;
    @(negedge clock);
    q = 32'hABCD; b = 32'h1234; r = 32'd0; start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 3 * W; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (n == 10) begin
        q = 32'h5555_5555; b = 32'hDEAD_BEEF; r = 32'h77; start = 1'b1;
      end
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    checks++;
    if (lat != W + 1 || p !== exp_p || p !== 64'h0C37_4FA4) begin
      errors++;
      $display("FAIL ignore_changes: p=%h lat=%0d required %h %0d", p, lat, exp_p, W + 1);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    int bb, lat, seen; logic dn, fv; logic [2*W-1:0] pv;
    seen = 0;
    @(negedge clock);
    q = 32'd100; b = 32'd200; r = 32'd5; start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b done=%b p=%h required 0 0 0", busy, done, p);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 2 * W; n++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0 || p !== '0) begin
      errors++;
      $display("FAIL reset_mid_nodone: activity=%0d p=%h required 0 0", seen, p);
    end
    launch(32'd2, 32'd2, 32'd0, bb, lat, dn, pv, fv);
    checks++;
    if (pv !== 64'd4 || lat != W + 1) begin
      errors++;
      $display("FAIL after_reset_op: p=%0d lat=%0d required 4 %0d", pv, lat, W + 1);
    end
  endtask

  task automatic test_hold;
    int changed, pulses;
    logic [2*W-1:0] held;
    changed = 0; pulses = 0;
    held = model(32'd2, 32'd2, 32'd0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      q = $urandom; b = $urandom; r = $urandom;
      if (p !== held) changed++;
      if (done) pulses++;
    end
    checks++;
    if (changed != 0 || pulses != 0) begin
      errors++;
      $display("FAIL idle_hold: p changed in %0d cycles, %0d done pulses (p=%h) required 0 0 %h",
               changed, pulses, p, held);
    end
  endtask

  initial begin
    test_reset;
    test_idle_no_start;
    test_basic;
    test_boundary;
    test_round_trip;
    test_random;
    test_back_to_back;
    test_ignore_changes;
    test_reset_mid;
    test_hold;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
Sequential shift-and-add multiplier that computes p = q*b + r, one multiplier bit per clock. It is the inverse of the sequential restoring divider: it takes a quotient, divisor and remainder and rebuilds the dividend. It serves as the datapath multiplier and as an in-circuit checker for divider results. It uses a start/busy/done handshake and holds its result until the next operation completes.

Parameters:
WIDTH, 32, operand width in bits; p is 2*WIDTH bits; WIDTH >= 2.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
q  input  WIDTH  multiplier (unsigned); sampled on the accepting edge
b  input  WIDTH  multiplicand (unsigned); sampled on the accepting edge
r  input  WIDTH  addend (unsigned); sampled on the accepting edge
busy  output  1  high while an operation is in flight (RUN)
done  output  1  one-cycle pulse: p holds a new result
p  output  2*WIDTH  result register q*b + r
fits  output  1  combinational, ~|p[2*WIDTH-1:WIDTH]; the result fits in WIDTH bits

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, p=0, so fits=1. Internal acc, mcand, mplier and cnt are cleared.
- Reset mid-operation: the operation aborts immediately. p returns to 0 and no done is produced. The first start after release is accepted normally.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: acc <= {0, r} (2*WIDTH bits), mcand <= {0, b} (2*WIDTH bits), mplier <= q, cnt <= 0, go to RUN.
  - start=0: stay in IDLE.
- RUN: one iteration per edge.
  - If mplier[0]=1, acc <= acc + mcand, added at 2*WIDTH bits.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - On the iteration with cnt == WIDTH-1: p <= final acc value (including that iteration's add), go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Outputs:
  - busy=1 exactly while in RUN; done=1 exactly while in DONE. Both are decoded from registered state, so no glitches.
  - p changes only on the edge entering DONE, or on reset. It holds between operations.
- Timing: start accepted at edge k gives busy=1 during cycles k+1..k+WIDTH and done=1 during cycle k+WIDTH+1. p is valid from the edge at k+WIDTH.
- Throughput: one operation per WIDTH+2 cycles with start held high, because start is ignored in RUN and DONE.
- Operands: q, b, r are captured only on the accepting edge. Changes during RUN/DONE have no effect.
- Width: the maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so acc never overflows and no carry-out is needed.
- cnt width: $clog2(WIDTH) bits; the comparison is against WIDTH-1 so cnt never wraps.
- start in the same cycle as reset release: reset dominates while asserted. A start seen at the first edge after release is accepted.

Test Plan:
1. q=7, b=9, r=3, one-cycle start pulse -> busy high for 32 cycles; done pulses once 33 cycles after the start edge; p=66 (0x42); fits=1.
2. q=b=r=0xFFFFFFFF -> p=0xFFFFFFFF_00000000, fits=0. Then q=0x10000, b=0x10000, r=0 -> p=0x1_00000000, fits=0.
3. Divider round trip: a=1000, b=7 gives q=142, r=6 -> p=1000, fits=1. Also b=0, q=5, r=0x1234 -> p=0x1234.
4. start held high for 100 cycles, q=3, b=5, r=1 -> done pulses exactly every 34 cycles, each with p=16. busy drops to 0 for exactly 2 cycles (DONE, IDLE) between runs.
5. Start q=0xABCD, b=0x1234, r=0. At RUN cycle 10, change q/b/r and pulse start -> the changes are ignored and p=0x0C374FA4. In a second run, assert reset_n=0 at RUN cycle 10 -> busy, done and p are 0 asynchronously and no done follows. The next op q=2, b=2, r=0 gives p=4.
6. After reset with no start -> p=0, fits=1, done never asserts. After one completed op, p stays constant for 200 idle cycles.
